// File: rtl/traffic_gen_pkg.sv
// Shared state encoding for the burst traffic generators (write now, read later).
package traffic_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } tg_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (priority over enable) that sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/burst_write_gen.sv
// Issues NUMBER_OF_BURSTS bursts of BURST_SIZE accepted FIFO writes, separated by
// IDLE_CYCLES gap cycles, and reports write/stall statistics for the run.
//
// state    | meaning
// ---------|---------------------------------------------------------------
// ST_IDLE  | waiting for start_i after reset
// ST_BURST | writing whenever wrdy_i is high; stalls counted when low
// ST_GAP   | forced idle between bursts, IDLE_CYCLES long
// ST_DONE  | run complete, statistics frozen until the next start_i
module burst_write_gen
  import traffic_gen_pkg::*;
#(
  parameter int BURST_SIZE       = 10,
  parameter int IDLE_CYCLES      = 10,
  parameter int NUMBER_OF_BURSTS = 10,
  parameter int CNT_W            = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             wrdy_i,
  output logic             we_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sent_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] max_stall_o,
  output logic [CNT_W-1:0] burst_idx_o
);

  localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(BURST_SIZE - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(NUMBER_OF_BURSTS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = (IDLE_CYCLES > 0) ? CNT_W'(IDLE_CYCLES - 1) : '0;
  localparam bit               NO_GAP     = (IDLE_CYCLES == 0);

  tg_state_e        state_q;
  logic             busy_q, done_q;
  logic [CNT_W-1:0] max_stall_q;

  logic             in_burst, in_gap, start_go, stall;
  logic             beat_last, run_last, gap_done, next_burst;
  logic [CNT_W-1:0] beat_cnt, gap_cnt, cur_stall, cur_stall_inc;

  assign in_burst   = (state_q == ST_BURST);
  assign in_gap     = (state_q == ST_GAP);
  assign start_go   = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign we_o       = in_burst && wrdy_i;
  assign stall      = in_burst && !wrdy_i;
  assign beat_last  = we_o && (beat_cnt == BEAT_LAST);
  assign run_last   = beat_last && (burst_idx_o == BURST_LAST);
  assign gap_done   = in_gap && (gap_cnt == GAP_LAST);
  assign next_burst = (beat_last && !run_last && NO_GAP) || gap_done;

  // Value the current-stall counter takes this edge; max tracking compares against it.
  assign cur_stall_inc = (&cur_stall) ? cur_stall : cur_stall + 1'b1;

  sat_counter #(.W(CNT_W)) u_sent_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(start_go), .en_i(we_o), .cnt_o(sent_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(start_go), .en_i(stall), .cnt_o(stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_cur_stall_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(start_go || we_o), .en_i(stall), .cnt_o(cur_stall)
  );

  sat_counter #(.W(CNT_W)) u_beat_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(start_go || beat_last), .en_i(we_o), .cnt_o(beat_cnt)
  );

  sat_counter #(.W(CNT_W)) u_gap_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(start_go || beat_last), .en_i(in_gap), .cnt_o(gap_cnt)
  );

  sat_counter #(.W(CNT_W)) u_burst_idx (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(start_go), .en_i(next_burst), .cnt_o(burst_idx_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      max_stall_q <= '0;
    end else begin
      if (stall && (cur_stall_inc > max_stall_q)) begin
        max_stall_q <= cur_stall_inc;
      end
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_go) begin
            state_q     <= ST_BURST;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            max_stall_q <= '0;
          end
        end
        ST_BURST: begin
          if (run_last) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (beat_last && !NO_GAP) begin
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            state_q <= ST_BURST;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign max_stall_o = max_stall_q;

endmodule
